// File: rtl/disp_seq_ctrl.sv
// disp_seq_ctrl: single-clock sequencer for a two-digit 7-segment display.
// It generates the digit dwell tick and scans the low and high digits. It
// debounces the "next source" button. It round-robins among NSRC byte-wide
// sources, and latches one sample per frame so both digits always agree.
module disp_seq_ctrl #(
  parameter int TICK_DIV = 2500000,
  parameter int DB_LEN   = 1250000,
  parameter int NSRC     = 4,
  parameter int SW       = $clog2(NSRC)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BTN_NEXT,
  input  logic [NSRC-1:0]   SRC_VALID,
  input  logic [8*NSRC-1:0] SRC_DATA,
  output logic              DIGIT_SEL,
  output logic [3:0]        NIBBLE,
  output logic              BLANK,
  output logic [SW-1:0]     SRC_SEL,
  output logic              FRAME_TICK
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_LEN - 1);

  typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} scan_state_t;

  // Search order starts one past the current source and wraps, so the current
  // source is considered last. The MSB of the result flags "a valid source exists".
  function automatic logic [SW:0] f_next_src(input logic [SW-1:0] cur,
                                             input logic [NSRC-1:0] valid);
    logic [SW:0] res;
    int          c;
    res = '0;
    for (int i = 1; i <= NSRC; i++) begin
      c = int'(cur) + i;
      if (c >= NSRC) begin
        c = c - NSRC;
      end
      if (!res[SW] && valid[SW'(c)]) begin
        res = {1'b1, SW'(c)};
      end
    end
    return res;
  endfunction

  logic [CW-1:0]  r_cnt;
  scan_state_t    r_state;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_db_level;
  logic [DBW-1:0] r_db_cnt;
  logic           r_pending;
  logic [SW-1:0]  r_src_sel;
  logic [7:0]     r_snap;
  logic           r_blank;
  logic           r_frame_tick;

  logic           w_tick;
  logic           w_boundary;
  logic           w_db_diff;
  logic           w_db_fire;
  logic           w_next_req;
  logic           w_need_search;
  logic [SW:0]    w_srch;
  logic [SW-1:0]  w_new_sel;
  logic [7:0]     w_new_data;

  // Tick, debounce-event and next-source decode from current register state.
  always_comb begin
    w_tick        = (r_cnt == TICK_LAST);
    w_boundary    = w_tick && (r_state == S_HIGH);
    w_db_diff     = (r_sync2 != r_db_level);
    w_db_fire     = w_db_diff && (r_db_cnt == DB_LAST);
    w_next_req    = w_db_fire && r_sync2;
    w_need_search = r_pending || w_next_req || !SRC_VALID[r_src_sel];
    w_srch        = f_next_src(r_src_sel, SRC_VALID);
    if (w_need_search && w_srch[SW]) begin
      w_new_sel = w_srch[SW-1:0];
    end else begin
      w_new_sel = r_src_sel;
    end
    w_new_data = 8'h00;
    for (int i = 0; i < NSRC; i++) begin
      if (SW'(i) == w_new_sel) begin
        w_new_data = SRC_DATA[8*i +: 8];
      end else begin
        w_new_data = w_new_data;
      end
    end
  end

  // Digit dwell counter, wraps to zero on each tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Button synchronizer and stability counter; any bounce restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= BTN_NEXT;
      r_sync2 <= r_sync1;
      if (w_db_fire) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else if (w_db_diff) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Scan FSM plus per-frame source choice, snapshot and blanking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_LOW;
      r_pending    <= 1'b0;
      r_src_sel    <= '0;
      r_snap       <= 8'h00;
      r_blank      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      case (r_state)
        S_LOW:   r_state <= w_tick ? S_HIGH : S_LOW;
        S_HIGH:  r_state <= w_tick ? S_LOW : S_HIGH;
        default: r_state <= S_LOW;
      endcase
      if (w_boundary) begin
        // A request arriving in this very cycle is folded into w_need_search.
        r_src_sel <= w_new_sel;
        r_snap    <= w_new_data;
        r_blank   <= ~|SRC_VALID;
        r_pending <= 1'b0;
      end else if (w_next_req) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Outputs are registers or a zero-latency function of registers only.
  always_comb begin
    DIGIT_SEL  = (r_state == S_HIGH);
    BLANK      = r_blank;
    SRC_SEL    = r_src_sel;
    FRAME_TICK = r_frame_tick;
    if (r_blank) begin
      NIBBLE = 4'h0;
    end else if (r_state == S_HIGH) begin
      NIBBLE = r_snap[7:4];
    end else begin
      NIBBLE = r_snap[3:0];
    end
  end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Self-checking bench for disp_seq_ctrl: directed scenarios plus a random
// phase, all compared cycle by cycle against a frame-level reference model.
module tb_disp_seq_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int NS = 4;
  localparam int SW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BTN_NEXT;
  logic [NS-1:0] SRC_VALID;
  logic [8*NS-1:0] SRC_DATA;
  logic          DIGIT_SEL;
  logic [3:0]    NIBBLE;
  logic          BLANK;
  logic [SW-1:0] SRC_SEL;
  logic          FRAME_TICK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_k;      // non-reset clock edges since the last reset
  int         m_sel;
  logic [7:0] m_snap;
  logic       m_blank;
  logic       m_ft;
  logic       m_pend;
  logic       m_level;
  int         m_run;
  logic       h_old, h_new;   // button samples taken two and one edges ago

  disp_seq_ctrl #(.TICK_DIV(TD), .DB_LEN(DB), .NSRC(NS), .SW(SW)) dut (
    .CLK(CLK), .RST(RST), .BTN_NEXT(BTN_NEXT), .SRC_VALID(SRC_VALID),
    .SRC_DATA(SRC_DATA), .DIGIT_SEL(DIGIT_SEL), .NIBBLE(NIBBLE), .BLANK(BLANK),
    .SRC_SEL(SRC_SEL), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic s, req, bnd, adv;
    if (RST) begin
      m_k = 0; m_sel = 0; m_snap = 8'h00; m_blank = 1'b1; m_ft = 1'b0;
      m_pend = 1'b0; m_level = 1'b0; m_run = 0; h_old = 1'b0; h_new = 1'b0;
    end else begin
      s   = h_old;
      req = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = s;
          m_run   = 0;
          req     = s;
        end
      end else begin
        m_run = 0;
      end
      h_old = h_new;
      h_new = BTN_NEXT;
      bnd = ((m_k % (2*TD)) == 2*TD-1);
      if (bnd) begin
        adv = m_pend | req;
        if (adv || !SRC_VALID[m_sel]) begin
          for (int off = 1; off <= NS; off++) begin
            if (SRC_VALID[(m_sel + off) % NS]) begin
              m_sel = (m_sel + off) % NS;
              break;
            end
          end
        end
        m_blank = (SRC_VALID == '0);
        m_snap  = SRC_DATA[8*m_sel +: 8];
        m_pend  = 1'b0;
      end else if (req) begin
        m_pend = 1'b1;
      end
      m_ft = bnd;
      m_k++;
    end
  endtask

  // One clock: edge, model update, then compare every output 1 ns later.
  task automatic cycle();
    logic       e_digit;
    logic [3:0] e_nib;
    @(posedge CLK);
    model_edge();
    #1;
    e_digit = ((m_k % (2*TD)) >= TD);
    e_nib   = m_blank ? 4'h0 : (e_digit ? m_snap[7:4] : m_snap[3:0]);
    check_eq("digit_sel", 32'(DIGIT_SEL), 32'(e_digit));
    check_eq("frame_tick", 32'(FRAME_TICK), 32'(m_ft));
    check_eq("blank", 32'(BLANK), 32'(m_blank));
    check_eq("src_sel", 32'(SRC_SEL), 32'(m_sel));
    check_eq("nibble", 32'(NIBBLE), 32'(e_nib));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run until the first cycle after a frame boundary (bounded to two frames).
  task automatic to_boundary();
    for (int i = 0; i < 4*TD; i++) begin
      cycle();
      if ((m_k % (2*TD)) == 0) break;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
  endtask

  // Clean press: held well past the debounce window, then released as long.
  task automatic press();
    BTN_NEXT = 1'b1;
    cycles(DB + 3);
    BTN_NEXT = 1'b0;
    cycles(DB + 3);
    to_boundary();
  endtask

  initial begin
    int hold;
    RST = 1'b1; BTN_NEXT = 1'b0; SRC_VALID = 4'hF; SRC_DATA = '0;
    do_reset();
    check_eq("rst_digit", 32'(DIGIT_SEL), 32'd0);
    check_eq("rst_blank", 32'(BLANK), 32'd1);
    check_eq("rst_nibble", 32'(NIBBLE), 32'd0);
    check_eq("rst_sel", 32'(SRC_SEL), 32'd0);
    check_eq("rst_ft", 32'(FRAME_TICK), 32'd0);

    // Snapshot holds for the whole frame despite a mid-frame data change.
    SRC_DATA[7:0] = 8'hA5;
    cycles(8);
    check_eq("ft_first", 32'(FRAME_TICK), 32'd1);
    check_eq("blank_first", 32'(BLANK), 32'd0);
    check_eq("nib_lo_a5", 32'(NIBBLE), 32'h5);
    SRC_DATA[7:0] = 8'h3C;
    cycles(4);
    check_eq("nib_hi_a5", 32'(NIBBLE), 32'hA);
    cycles(4);
    check_eq("nib_lo_3c", 32'(NIBBLE), 32'hC);
    cycles(4);
    check_eq("nib_hi_3c", 32'(NIBBLE), 32'h3);

    // Bouncing press yields exactly one advance.
    BTN_NEXT = 1'b1; cycle();
    BTN_NEXT = 1'b0; cycle();
    BTN_NEXT = 1'b1; cycles(5);
    BTN_NEXT = 1'b0; cycles(6);
    to_boundary();
    check_eq("bounce_sel", 32'(SRC_SEL), 32'd1);
    to_boundary();
    check_eq("bounce_sel_hold", 32'(SRC_SEL), 32'd1);

    // Sparse valid set with wrap-around.
    do_reset();
    SRC_VALID = 4'b1001;
    to_boundary();
    check_eq("sparse_sel0", 32'(SRC_SEL), 32'd0);
    press();
    check_eq("sparse_sel3", 32'(SRC_SEL), 32'd3);
    press();
    check_eq("sparse_wrap", 32'(SRC_SEL), 32'd0);

    // All sources invalid, then one restored.
    cycles(2);
    SRC_VALID = 4'b0000;
    to_boundary();
    check_eq("none_blank", 32'(BLANK), 32'd1);
    check_eq("none_nibble", 32'(NIBBLE), 32'd0);
    check_eq("none_sel", 32'(SRC_SEL), 32'd0);
    SRC_VALID = 4'b0100;
    to_boundary();
    check_eq("restore_sel", 32'(SRC_SEL), 32'd2);
    check_eq("restore_blank", 32'(BLANK), 32'd0);

    // Request landing exactly on the boundary cycle is honoured there.
    SRC_VALID = 4'hF;
    to_boundary();
    cycles(3);
    BTN_NEXT = 1'b1;
    to_boundary();
    check_eq("req_at_bnd", 32'(SRC_SEL), 32'd3);
    BTN_NEXT = 1'b0;
    cycles(DB + 4);

    // Reset mid-frame.
    cycles(3);
    RST = 1'b1;
    cycle();
    check_eq("midrst_sel", 32'(SRC_SEL), 32'd0);
    check_eq("midrst_blank", 32'(BLANK), 32'd1);
    check_eq("midrst_digit", 32'(DIGIT_SEL), 32'd0);
    RST = 1'b0;

    // Random phase.
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        BTN_NEXT = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) SRC_VALID = 4'($urandom_range(0, 15));
      SRC_DATA = 32'($urandom);
      RST = ($urandom_range(0, 399) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
